// File: rtl/cache_pkg.sv
// Shared cache definitions: miss-handling FSM states and address layout constants.
package cache_pkg;

  localparam int BYTE_OFFSET_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    VICTIM,
    WB_RD,
    WB_REQ,
    WB_WAIT,
    RF_REQ,
    RF_WAIT,
    TAG_WR
  } miss_state_t;

endpackage

// File: rtl/cache_miss_controller_if.sv
// PULPino-style req/gnt/rvalid memory bus between the miss controller and memory.
interface cache_miss_controller_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/cache_miss_controller.sv
// Line refill sequencer: picks a victim way, writes it back if dirty, fetches the
// new line word by word over the memory bus, then installs the tag.
module cache_miss_controller
  import cache_pkg::*;
#(
  parameter int WAY_COUNT  = 2,
  parameter int SET_COUNT  = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32,
  localparam int WB = $clog2(WAY_COUNT),
  localparam int SB = $clog2(SET_COUNT),
  localparam int OB = $clog2(LINE_WORDS),
  localparam int TB = ADDR_WIDTH - SB - OB - BYTE_OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  miss_ready,
  output logic                  done,
  output logic [WB-1:0]         done_way,
  output logic [SB-1:0]         rp_set,
  input  logic [WB-1:0]         rp_way,
  input  logic                  rp_ready,
  output logic                  rp_taken,
  output logic [SB-1:0]         tag_set,
  output logic [WB-1:0]         tag_way,
  input  logic                  victim_valid,
  input  logic                  victim_dirty,
  input  logic [TB-1:0]         victim_tag,
  output logic                  tag_we,
  output logic [TB-1:0]         tag_wtag,
  output logic [SB-1:0]         data_set,
  output logic [WB-1:0]         data_way,
  output logic [OB-1:0]         data_word,
  output logic                  data_re,
  input  logic [31:0]           data_rdata,
  output logic                  data_we,
  output logic [31:0]           data_wdata,
  cache_miss_controller_if.master mem
);

  miss_state_t   state_q, state_d;
  logic [SB-1:0] set_q;
  logic [TB-1:0] miss_tag_q;
  logic [TB-1:0] victim_tag_q;
  logic [WB-1:0] way_q;
  logic [OB-1:0] k_q;
  logic [31:0]   wb_data_q;
  logic          wb_first_q;
  logic          k_last;
  logic          unused_offset;

  assign k_last        = (k_q == OB'(LINE_WORDS - 1));
  assign unused_offset = ^miss_addr[OB+BYTE_OFFSET_BITS-1:0];

  assign rp_set    = set_q;
  assign tag_set   = set_q;
  assign tag_wtag  = miss_tag_q;
  assign data_set  = set_q;
  assign data_way  = way_q;
  assign data_word = k_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Miss context, victim way/tag and the word counter; the SRAM read word is
  // only valid in the first WB_REQ cycle, so it is held for a stalled grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_q        <= '0;
      miss_tag_q   <= '0;
      victim_tag_q <= '0;
      way_q        <= '0;
      k_q          <= '0;
      wb_data_q    <= '0;
      wb_first_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_valid) begin
            set_q      <= miss_addr[BYTE_OFFSET_BITS+OB +: SB];
            miss_tag_q <= miss_addr[ADDR_WIDTH-1 -: TB];
            k_q        <= '0;
          end
        end
        VICTIM: begin
          if (rp_ready) begin
            way_q        <= rp_way;
            victim_tag_q <= victim_tag;
          end
        end
        WB_RD:   wb_first_q <= 1'b1;
        WB_REQ: begin
          if (wb_first_q) wb_data_q <= data_rdata;
          wb_first_q <= 1'b0;
        end
        WB_WAIT: begin
          if (mem.mem_rvalid) k_q <= k_last ? '0 : k_q + OB'(1);
        end
        RF_WAIT: begin
          if (mem.mem_rvalid && !k_last) k_q <= k_q + OB'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    miss_ready     = 1'b0;
    done           = 1'b0;
    done_way       = '0;
    rp_taken       = 1'b0;
    tag_way        = way_q;
    tag_we         = 1'b0;
    data_re        = 1'b0;
    data_we        = 1'b0;
    data_wdata     = '0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_d = VICTIM;
      end
      VICTIM: begin
        tag_way = rp_way;
        if (rp_ready) state_d = (victim_valid && victim_dirty) ? WB_RD : RF_REQ;
      end
      WB_RD: begin
        data_re = 1'b1;
        state_d = WB_REQ;
      end
      WB_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {victim_tag_q, set_q, k_q, {BYTE_OFFSET_BITS{1'b0}}};
        mem.mem_wdata = wb_first_q ? data_rdata : wb_data_q;
        if (mem.mem_gnt) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem.mem_rvalid) state_d = k_last ? RF_REQ : WB_RD;
      end
      RF_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {miss_tag_q, set_q, k_q, {BYTE_OFFSET_BITS{1'b0}}};
        if (mem.mem_gnt) state_d = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem.mem_rvalid) begin
          data_we    = 1'b1;
          data_wdata = mem.mem_rdata;
          state_d    = k_last ? TAG_WR : RF_REQ;
        end
      end
      TAG_WR: begin
        tag_we   = 1'b1;
        rp_taken = 1'b1;
        done     = 1'b1;
        done_way = way_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/cache_miss_controller.md
# cache_miss_controller

- Sequences a line refill for the set-associative instruction/data cache on a miss:
  - queries the replacement policy for a victim way;
  - writes the victim line back to memory if it is valid and dirty;
  - fetches the new line word by word over the PULPino req/gnt/rvalid bus;
  - updates the tag array, then pulses `rp_taken` to advance the policy.
- Sits between the cache lookup stage, `replacement_policy`, the tag/data SRAMs and the memory bus.
- Handles one miss at a time.

## Interface
- `WAY_COUNT`, 2, associativity (power of two ≥ 2)
- `SET_COUNT`, 64, sets (power of two)
- `LINE_WORDS`, 4, 32-bit words per line (power of two ≥ 2)
- `ADDR_WIDTH`, 32, byte address width
- Derived widths:
  - WB = clog2(WAY_COUNT)
  - SB = clog2(SET_COUNT)
  - OB = clog2(LINE_WORDS)
  - TB = ADDR_WIDTH−SB−OB−2
- Ports:
  - `clk`  in  1  clock
  - `reset`  in  1  asynchronous, active-high
  - `miss_valid`  in  1  lookup stage presents a miss
  - `miss_addr`  in  ADDR_WIDTH  missing address; offset bits ignored
  - `miss_ready`  out  1  high only in IDLE
  - `done`  out  1  one-cycle pulse, line installed
  - `done_way`  out  WB  way the line was installed in; valid with `done`
  - `rp_set`  out  SB  set presented to the replacement policy
  - `rp_way`  in  WB  policy's replacement way
  - `rp_ready`  in  1  policy output valid
  - `rp_taken`  out  1  one-cycle pulse, victim consumed
  - `tag_set` / `tag_way`  out  SB / WB  tag array address
  - `victim_valid` / `victim_dirty` / `victim_tag`  in  1 / 1 / TB  combinational tag read
  - `tag_we`  out  1  write the tag entry with valid=1, dirty=0, tag=`miss_tag`
  - `tag_wtag`  out  TB  `miss_tag`
  - `data_set` / `data_way` / `data_word`  out  SB / WB / OB  data array address
  - `data_re`  out  1  data read; `data_rdata` valid next cycle
  - `data_rdata`  in  32  data array read data
  - `data_we`  out  1  data array write
  - `data_wdata`  out  32  data array write data
  - `mem_req` / `mem_we`  out  1 / 1  bus request / write
  - `mem_addr` / `mem_wdata`  out  ADDR_WIDTH / 32  bus address / write data
  - `mem_gnt` / `mem_rvalid`  in  1 / 1  bus grant / response valid
  - `mem_rdata`  in  32  bus read data

## Operation
- Acceptance: `miss_valid && miss_ready` latches `miss_tag`, `miss_set` and clears word counter k.
- `rp_set` and `tag_set` always equal the latched set.
- FSM states:
  - **IDLE**: all strobes low. `mem_rvalid` is ignored.
  - **VICTIM**: `tag_way = rp_way`. Waits while `rp_ready` is low. When it is high, latches way, `victim_tag` and `victim_valid & victim_dirty`, then:
    - if the valid-and-dirty flag is set → WB_RD;
    - otherwise → RF_REQ.
  - **WB_RD**: `data_re` for word k → WB_REQ.
  - **WB_REQ**: `mem_req=1`, `mem_we=1`, `mem_addr={victim_tag, set, k, 2'b00}`, `mem_wdata` = `data_rdata` captured at state entry. Held until `mem_gnt` → WB_WAIT.
  - **WB_WAIT**: waits for `mem_rvalid`. Then:
    - k==LINE_WORDS−1 → k=0, RF_REQ;
    - otherwise → k+1, WB_RD.
  - **RF_REQ**: `mem_req=1`, `mem_we=0`, `mem_addr={miss_tag, set, k, 2'b00}`. Held until `mem_gnt` → RF_WAIT.
  - **RF_WAIT**: on `mem_rvalid`, `data_we=1` with `data_wdata=mem_rdata` at word k. Then:
    - last word → TAG_WR;
    - otherwise → k+1, RF_REQ.
  - **TAG_WR**: `tag_we`, `rp_taken`, `done` pulsed together → IDLE.
- Boundary rules:
  - All `mem_*` outputs are stable while `mem_req && !mem_gnt`.
  - `mem_rvalid` is ignored outside the WAIT states; it never arrives in the grant cycle.
  - An invalid victim is never written back, even if its dirty bit is set.
  - `rp_taken` fires exactly once per accepted miss.
  - `miss_valid` while busy is stalled via `miss_ready=0`.
  - Reset mid-miss returns to IDLE immediately and abandons the bus transaction. Nothing is written after reset.

## Timing
- Reset values: `miss_ready=1`; all other outputs 0, address/data outputs 0.
- Outputs in states other than TAG_WR/IDLE are registered state decodes. Addresses come from registers only.
- Clean miss, with `gnt` in the request cycle and `rvalid` one cycle later:
  - accept at cycle 0, VICTIM at cycle 1;
  - 2 cycles per word;
  - `done` at cycle 2+2·LINE_WORDS (cycle 10 for 4 words).
- A dirty miss adds 3·LINE_WORDS cycles (`done` at cycle 22).
- `miss_ready` is high again the cycle after `done`.

## Structure
- Shared `cache_pkg` holds:
  - the `miss_state_t` enum (IDLE, VICTIM, WB_RD, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, TAG_WR);
  - the byte-offset width constant (2).
- No sub-module: the word counter and FSM are inline.
- `replacement_policy` is instantiated alongside in the cache top, not inside this block.

## Test plan
- **Clean miss, invalid victim:** addr 0x0000_1230, `rp_way=1`, gnt immediate, rvalid +1.
  - 4 reads at 0x1230/34/38/3C;
  - `data_we` words 0–3;
  - `done` at cycle 10, `done_way=1`, one `rp_taken`.
- **Dirty victim, tag 0x5:** 4 writes to `{5, set, k, 00}` carrying the captured `data_rdata`, strictly before any read; `done` at cycle 22.
- **Grant stall:** `mem_gnt` low 5 cycles. `mem_req`/`addr`/`we`/`wdata` constant throughout; latency grows by 5 per stalled beat.
- **`rp_ready` low 3 cycles in VICTIM:** no bus activity; latency +3.
- **Busy and stray response:** second `miss_valid` during refill sees `miss_ready=0` until the cycle after `done`. Spurious `mem_rvalid` in IDLE causes no writes.
- **Reset in WB_WAIT:** all outputs 0 next edge; no `tag_we` or `done`; a new miss afterwards completes normally.
